// File: rtl/interval_timer_ctrl_if.sv
// Start/stop handshake and counter-control bundle between a requester and the interval timer controller.
// The requester side also plays the role of the 4-bit loadable counter (cnt_value).
interface interval_timer_ctrl_if;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] start_value;
    logic       periodic;
    logic       stop;
    logic       done_ack;
    logic       cnt_load;
    logic [3:0] cnt_load_data;
    logic [3:0] cnt_value;
    logic       busy;
    logic       tick;
    logic       expired;
    logic [7:0] tick_cnt;

    modport master (
        output start_valid, start_value, periodic, stop, done_ack, cnt_value,
        input  start_ready, cnt_load, cnt_load_data, busy, tick, expired, tick_cnt
    );

    modport slave (
        input  start_valid, start_value, periodic, stop, done_ack, cnt_value,
        output start_ready, cnt_load, cnt_load_data, busy, tick, expired, tick_cnt
    );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Sequencer for a free-running 4-bit loadable counter: presets it, watches for terminal count 4'hF,
// and reports ticks/expiry in one-shot or auto-reload mode.
module interval_timer_ctrl (
    input  logic                  clk,
    input  logic                  reset_n,
    interval_timer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] preset_q, preset_d;
    logic       mode_q, mode_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;

    logic       start_ready;
    logic       cnt_load;
    logic [3:0] cnt_load_data;
    logic       busy;
    logic       tick;
    logic       expired;
    logic       terminal;

    assign terminal = (bus.cnt_value == 4'hF);

    always_comb begin
        state_d       = state_q;
        preset_d      = preset_q;
        mode_d        = mode_q;
        tick_cnt_d    = tick_cnt_q;
        start_ready   = 1'b0;
        // Loading the current count back into the counter freezes it.
        cnt_load      = 1'b1;
        cnt_load_data = bus.cnt_value;
        busy          = 1'b0;
        tick          = 1'b0;
        expired       = 1'b0;

        case (state_q)
            IDLE: begin
                start_ready   = 1'b1;
                cnt_load_data = 4'h0;
                if (bus.start_valid) begin
                    preset_d   = bus.start_value;
                    mode_d     = bus.periodic;
                    tick_cnt_d = 8'h00;
                    state_d    = ARM;
                end
            end
            ARM: begin
                busy          = 1'b1;
                cnt_load_data = preset_q;
                state_d       = bus.stop ? IDLE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (terminal) begin
                    tick = 1'b1;
                    if (tick_cnt_q != 8'hFF) begin
                        tick_cnt_d = tick_cnt_q + 8'h01;
                    end
                    if (mode_q) begin
                        cnt_load_data = preset_q;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_load = 1'b0;
                end
                // Abort overrides both the reload and the move to DONE, but the tick above still counts.
                if (bus.stop) begin
                    cnt_load      = 1'b1;
                    cnt_load_data = bus.cnt_value;
                    state_d       = IDLE;
                end
            end
            DONE: begin
                expired = 1'b1;
                if (bus.done_ack || bus.stop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            preset_q   <= 4'h0;
            mode_q     <= 1'b0;
            tick_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            mode_q     <= mode_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.start_ready   = start_ready;
    assign bus.cnt_load      = cnt_load;
    assign bus.cnt_load_data = cnt_load_data;
    assign bus.busy          = busy;
    assign bus.tick          = tick;
    assign bus.expired       = expired;
    assign bus.tick_cnt      = tick_cnt_q;
endmodule
